// File: rtl/character_motion_ctrl_pkg.sv
// Shared types and defaults for the character motion sequencer: motion states, speeds,
// sprite geometry and screen width, plus small 13-bit signed clamp helpers.
package character_motion_ctrl_pkg;

   typedef logic [1:0] motion_state_t;

   localparam motion_state_t WALK  = 2'd0;
   localparam motion_state_t CLIMB = 2'd1;
   localparam motion_state_t JUMP  = 2'd2;
   localparam motion_state_t FALL  = 2'd3;

   localparam logic [11:0] DEF_START_X     = 12'd64;
   localparam logic [11:0] DEF_START_Y     = 12'd700;
   localparam int unsigned DEF_WALK_SPEED  = 2;
   localparam int unsigned DEF_CLIMB_SPEED = 2;
   localparam int unsigned DEF_RAMP_DIV    = 8;
   localparam int unsigned DEF_JUMP_FRAMES = 12;
   localparam int unsigned DEF_JUMP_SPEED  = 3;
   localparam int unsigned DEF_FALL_SPEED  = 3;

   localparam int unsigned HOR_PIXELS       = 1024;
   localparam int unsigned CHARACTER_WIDTH  = 48;
   localparam int unsigned CHARACTER_HEIGHT = 64;

   // Saturate a 13-bit signed intermediate into the unsigned 12-bit position range.
   function automatic logic [11:0] sat12(input logic signed [12:0] v);
      if (v < 13'sd0) begin
         return 12'd0;
      end
      return v[11:0];
   endfunction

   function automatic logic [11:0] clamp12(input logic signed [12:0] v,
                                          input logic signed [12:0] lo,
                                          input logic signed [12:0] hi);
      if (v < lo) begin
         return sat12(lo);
      end
      if (v > hi) begin
         return sat12(hi);
      end
      return sat12(v);
   endfunction

endpackage

// File: rtl/character_motion_ctrl.sv
// Per-frame movement sequencer: owns the character position and walks it through
// WALK / CLIMB / JUMP / FALL using keyboard intents and map-collision query results.
module character_motion_ctrl
   import character_motion_ctrl_pkg::*;
#(
   parameter logic [11:0] START_X     = DEF_START_X,
   parameter logic [11:0] START_Y     = DEF_START_Y,
   parameter int unsigned WALK_SPEED  = DEF_WALK_SPEED,
   parameter int unsigned CLIMB_SPEED = DEF_CLIMB_SPEED,
   parameter int unsigned RAMP_DIV    = DEF_RAMP_DIV,
   parameter int unsigned JUMP_FRAMES = DEF_JUMP_FRAMES,
   parameter int unsigned JUMP_SPEED  = DEF_JUMP_SPEED,
   parameter int unsigned FALL_SPEED  = DEF_FALL_SPEED
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_tick,
   input  logic          key_left,
   input  logic          key_right,
   input  logic          key_up,
   input  logic          key_down,
   input  logic          key_jump,
   input  logic          ladder,
   input  logic [1:0]    ramp,
   input  logic [11:0]   limit_ypos_min,
   input  logic [11:0]   limit_ypos_max,
   input  logic          end_of_ramp,
   input  logic [11:0]   landing_ypos,
   output logic [11:0]   xpos,
   output logic [11:0]   ypos,
   output motion_state_t state,
   output logic          facing_left
);

   localparam int unsigned CNT_W = $clog2(JUMP_FRAMES + 1);

   localparam logic signed [12:0] WALK_STEP  = 13'(WALK_SPEED);
   localparam logic signed [12:0] CLIMB_STEP = 13'(CLIMB_SPEED);
   localparam logic signed [12:0] JUMP_STEP  = 13'(JUMP_SPEED);
   localparam logic signed [12:0] FALL_STEP  = 13'(FALL_SPEED);
   localparam logic signed [12:0] X_MAX      = 13'(HOR_PIXELS - CHARACTER_WIDTH);

   motion_state_t      state_q, state_d;
   logic [11:0]        xpos_q, xpos_d;
   logic [11:0]        ypos_q, ypos_d;
   logic               facing_q, facing_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         accum_q, accum_d;
   logic [11:0]        ground_q, ground_d;
   logic [11:0]        target_q, target_d;

   logic               move_l, move_r, moving;
   logic               climb_up, climb_dn;
   logic               on_ramp, step_up, at_limit, climb_exit;
   logic signed [12:0] x_s, y_s, x_step, x_walk_s;
   logic [11:0]        x_walk;
   logic               facing_walk;
   logic [4:0]         acc_sum;

   // Horizontal intent and the shared walk/jump/fall x update.
   always_comb begin
      move_l      = key_left & ~key_right;
      move_r      = key_right & ~key_left;
      moving      = move_l | move_r;
      climb_up    = key_up & ~key_down;
      climb_dn    = key_down & ~key_up;
      x_s         = $signed({1'b0, xpos_q});
      y_s         = $signed({1'b0, ypos_q});
      x_step      = 13'sd0;
      if (move_r) begin
         x_step = WALK_STEP;
      end else if (move_l) begin
         x_step = -WALK_STEP;
      end
      x_walk_s    = x_s + x_step;
      x_walk      = clamp12(x_walk_s, 13'sd0, X_MAX);
      facing_walk = move_l ? 1'b1 : (move_r ? 1'b0 : facing_q);
   end

   // Ramp step direction and ladder exit conditions.
   always_comb begin
      on_ramp    = (ramp == 2'b01) || (ramp == 2'b10);
      step_up    = ((ramp == 2'b01) && move_r) || ((ramp == 2'b10) && move_l);
      acc_sum    = {1'b0, accum_q} + 5'(WALK_SPEED);
      at_limit   = (ypos_q == limit_ypos_min) || (ypos_q == limit_ypos_max);
      climb_exit = ~ladder || (at_limit && (key_left ^ key_right));
   end

   always_comb begin
      state_d  = state_q;
      xpos_d   = xpos_q;
      ypos_d   = ypos_q;
      facing_d = facing_q;
      cnt_d    = cnt_q;
      accum_d  = accum_q;
      ground_d = ground_q;
      target_d = target_q;

      if (frame_tick) begin
         case (state_q)
            WALK: begin
               xpos_d   = x_walk;
               facing_d = facing_walk;
               if (!on_ramp) begin
                  accum_d = 4'd0;
               end else if (moving) begin
                  if (acc_sum >= 5'(RAMP_DIV)) begin
                     accum_d = 4'(acc_sum - 5'(RAMP_DIV));
                     ypos_d  = step_up ? sat12(y_s - 13'sd1) : sat12(y_s + 13'sd1);
                  end else begin
                     accum_d = acc_sum[3:0];
                  end
               end

               if (ladder && (key_up ^ key_down)) begin
                  state_d = CLIMB;
                  accum_d = 4'd0;
               end else if (key_jump) begin
                  state_d  = JUMP;
                  ground_d = ypos_q;
                  cnt_d    = '0;
                  accum_d  = 4'd0;
               end else if (end_of_ramp && moving) begin
                  state_d  = FALL;
                  target_d = landing_ypos;
                  accum_d  = 4'd0;
               end
            end

            CLIMB: begin
               if (climb_exit) begin
                  state_d = WALK;
               end else if (climb_up) begin
                  ypos_d = clamp12(y_s - CLIMB_STEP, $signed({1'b0, limit_ypos_min}),
                                   $signed({1'b0, limit_ypos_max}));
               end else if (climb_dn) begin
                  ypos_d = clamp12(y_s + CLIMB_STEP, $signed({1'b0, limit_ypos_min}),
                                   $signed({1'b0, limit_ypos_max}));
               end
            end

            JUMP: begin
               xpos_d   = x_walk;
               facing_d = facing_walk;
               ypos_d   = sat12(y_s - JUMP_STEP);
               cnt_d    = cnt_q + 1'b1;
               // Last rising frame hands over to FALL aimed back at the take-off height.
               if (cnt_q == CNT_W'(JUMP_FRAMES - 1)) begin
                  state_d  = FALL;
                  target_d = ground_q;
                  cnt_d    = '0;
               end
            end

            FALL: begin
               xpos_d   = x_walk;
               facing_d = facing_walk;
               if ((y_s + FALL_STEP) >= $signed({1'b0, target_q})) begin
                  ypos_d  = target_q;
                  state_d = WALK;
               end else begin
                  ypos_d = sat12(y_s + FALL_STEP);
               end
            end

            default: state_d = WALK;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= WALK;
         xpos_q   <= START_X;
         ypos_q   <= START_Y;
         facing_q <= 1'b0;
         cnt_q    <= '0;
         accum_q  <= 4'd0;
         ground_q <= START_Y;
         target_q <= START_Y;
      end else begin
         state_q  <= state_d;
         xpos_q   <= xpos_d;
         ypos_q   <= ypos_d;
         facing_q <= facing_d;
         cnt_q    <= cnt_d;
         accum_q  <= accum_d;
         ground_q <= ground_d;
         target_q <= target_d;
      end
   end

   assign xpos        = xpos_q;
   assign ypos        = ypos_q;
   assign state       = state_q;
   assign facing_left = facing_q;

endmodule

// File: tb/tb_character_motion_ctrl.sv
// Directed self-checking bench for character_motion_ctrl; each task drives one scenario.
module tb_character_motion_ctrl;
   import character_motion_ctrl_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          frame_tick;
   logic          key_left, key_right, key_up, key_down, key_jump;
   logic          ladder;
   logic [1:0]    ramp;
   logic [11:0]   limit_ypos_min, limit_ypos_max;
   logic          end_of_ramp;
   logic [11:0]   landing_ypos;
   logic [11:0]   xpos, ypos;
   motion_state_t state;
   logic          facing_left;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   character_motion_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .frame_tick     (frame_tick),
      .key_left       (key_left),
      .key_right      (key_right),
      .key_up         (key_up),
      .key_down       (key_down),
      .key_jump       (key_jump),
      .ladder         (ladder),
      .ramp           (ramp),
      .limit_ypos_min (limit_ypos_min),
      .limit_ypos_max (limit_ypos_max),
      .end_of_ramp    (end_of_ramp),
      .landing_ypos   (landing_ypos),
      .xpos           (xpos),
      .ypos           (ypos),
      .state          (state),
      .facing_left    (facing_left)
   );

   task automatic clear_inputs();
      frame_tick     = 1'b0;
      key_left       = 1'b0;
      key_right      = 1'b0;
      key_up         = 1'b0;
      key_down       = 1'b0;
      key_jump       = 1'b0;
      ladder         = 1'b0;
      ramp           = 2'b00;
      limit_ypos_min = 12'd0;
      limit_ypos_max = 12'd0;
      end_of_ramp    = 1'b0;
      landing_ypos   = 12'd0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One frame: tick pulse for one cycle, then one idle cycle; returns 1 time unit after an edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         @(posedge clk);
         #1 frame_tick = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (xpos !== 12'd64 || ypos !== 12'd700) begin
         n_fail++;
         $display("FAIL reset_pos: got x=%0d y=%0d, expected x=64 y=700", xpos, ypos);
      end
      n_checks++;
      if (state !== WALK || facing_left !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got state=%0d facing=%0b, expected 0/0", state, facing_left);
      end
      // Tick coincident with reset is ignored.
      key_right  = 1'b1;
      rst        = 1'b1;
      frame_tick = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      frame_tick = 1'b0;
      key_right  = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (xpos !== 12'd64) begin
         n_fail++;
         $display("FAIL reset_tick_ignored: got x=%0d, expected 64", xpos);
      end
   endtask

   task automatic test_walk();
      do_reset();
      key_right = 1'b1;
      tick(1);
      n_checks++;
      if (xpos !== 12'd66) begin
         n_fail++;
         $display("FAIL walk_latency: got x=%0d, expected 66", xpos);
      end
      tick(9);
      n_checks++;
      if (xpos !== 12'd84 || ypos !== 12'd700 || state !== WALK || facing_left !== 1'b0) begin
         n_fail++;
         $display("FAIL walk_right: got x=%0d y=%0d st=%0d f=%0b, expected 84 700 0 0",
                  xpos, ypos, state, facing_left);
      end
      key_right = 1'b0;
      // Registers hold without a tick.
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (xpos !== 12'd84) begin
         n_fail++;
         $display("FAIL walk_hold: got x=%0d, expected 84", xpos);
      end
   endtask

   task automatic test_climb();
      do_reset();
      ladder         = 1'b1;
      limit_ypos_min = 12'd400;
      limit_ypos_max = 12'd600;
      key_up         = 1'b1;
      tick(1);
      n_checks++;
      if (state !== CLIMB) begin
         n_fail++;
         $display("FAIL climb_enter: got state=%0d, expected %0d", state, CLIMB);
      end
      tick(149);
      n_checks++;
      if (ypos !== 12'd400 || state !== CLIMB || xpos !== 12'd64) begin
         n_fail++;
         $display("FAIL climb_top: got x=%0d y=%0d st=%0d, expected 64 400 1", xpos, ypos, state);
      end
      key_up   = 1'b0;
      key_left = 1'b1;
      tick(1);
      n_checks++;
      if (state !== WALK || xpos !== 12'd64 || ypos !== 12'd400) begin
         n_fail++;
         $display("FAIL climb_exit: got x=%0d y=%0d st=%0d, expected 64 400 0", xpos, ypos, state);
      end
      tick(1);
      n_checks++;
      if (xpos !== 12'd62 || facing_left !== 1'b1) begin
         n_fail++;
         $display("FAIL climb_walk_off: got x=%0d f=%0b, expected 62 1", xpos, facing_left);
      end
   endtask

   task automatic test_jump();
      do_reset();
      key_jump = 1'b1;
      tick(1);
      key_jump = 1'b0;
      n_checks++;
      if (state !== JUMP || ypos !== 12'd700) begin
         n_fail++;
         $display("FAIL jump_enter: got st=%0d y=%0d, expected 2 700", state, ypos);
      end
      tick(11);
      n_checks++;
      if (state !== JUMP || ypos !== 12'd667) begin
         n_fail++;
         $display("FAIL jump_rise: got st=%0d y=%0d, expected 2 667", state, ypos);
      end
      tick(1);
      n_checks++;
      if (state !== FALL || ypos !== 12'd664) begin
         n_fail++;
         $display("FAIL jump_apex: got st=%0d y=%0d, expected 3 664", state, ypos);
      end
      tick(11);
      n_checks++;
      if (state !== FALL || ypos !== 12'd697) begin
         n_fail++;
         $display("FAIL jump_descend: got st=%0d y=%0d, expected 3 697", state, ypos);
      end
      tick(1);
      n_checks++;
      if (state !== WALK || ypos !== 12'd700 || xpos !== 12'd64) begin
         n_fail++;
         $display("FAIL jump_land: got st=%0d x=%0d y=%0d, expected 0 64 700", state, xpos, ypos);
      end
   endtask

   task automatic test_fall();
      do_reset();
      end_of_ramp  = 1'b1;
      landing_ypos = 12'd760;
      key_right    = 1'b1;
      tick(1);
      end_of_ramp = 1'b0;
      n_checks++;
      if (state !== FALL || xpos !== 12'd66 || ypos !== 12'd700) begin
         n_fail++;
         $display("FAIL fall_enter: got st=%0d x=%0d y=%0d, expected 3 66 700", state, xpos, ypos);
      end
      tick(19);
      n_checks++;
      if (state !== FALL || ypos !== 12'd757) begin
         n_fail++;
         $display("FAIL fall_mid: got st=%0d y=%0d, expected 3 757", state, ypos);
      end
      tick(1);
      n_checks++;
      if (state !== WALK || ypos !== 12'd760 || xpos !== 12'd106) begin
         n_fail++;
         $display("FAIL fall_land: got st=%0d x=%0d y=%0d, expected 0 106 760", state, xpos, ypos);
      end
      key_right = 1'b0;
   endtask

   task automatic test_ramp();
      do_reset();
      ramp      = 2'b01;
      key_right = 1'b1;
      tick(3);
      n_checks++;
      if (ypos !== 12'd700) begin
         n_fail++;
         $display("FAIL ramp_accum: got y=%0d, expected 700", ypos);
      end
      tick(5);
      n_checks++;
      if (ypos !== 12'd698 || xpos !== 12'd80) begin
         n_fail++;
         $display("FAIL ramp_up: got x=%0d y=%0d, expected 80 698", xpos, ypos);
      end
      ramp = 2'b10;
      tick(8);
      n_checks++;
      if (ypos !== 12'd700 || xpos !== 12'd96) begin
         n_fail++;
         $display("FAIL ramp_down: got x=%0d y=%0d, expected 96 700", xpos, ypos);
      end
      key_right = 1'b0;
      ramp      = 2'b00;
   endtask

   task automatic test_edges();
      do_reset();
      key_left = 1'b1;
      tick(40);
      n_checks++;
      if (xpos !== 12'd0 || facing_left !== 1'b1) begin
         n_fail++;
         $display("FAIL left_clamp: got x=%0d f=%0b, expected 0 1", xpos, facing_left);
      end
      key_right = 1'b1;
      tick(3);
      n_checks++;
      if (xpos !== 12'd0 || facing_left !== 1'b1) begin
         n_fail++;
         $display("FAIL both_keys: got x=%0d f=%0b, expected 0 1", xpos, facing_left);
      end
      key_left  = 1'b0;
      key_right = 1'b0;
   endtask

   task automatic test_reset_mid_jump();
      do_reset();
      key_right = 1'b1;
      key_jump  = 1'b1;
      tick(1);
      key_jump = 1'b0;
      tick(5);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      key_right = 1'b0;
      n_checks++;
      if (xpos !== 12'd64 || ypos !== 12'd700 || state !== WALK || facing_left !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_jump: got x=%0d y=%0d st=%0d f=%0b, expected 64 700 0 0",
                  xpos, ypos, state, facing_left);
      end
      // No residual jump counter or target: a fresh jump takes the full 12 rising frames.
      key_jump = 1'b1;
      tick(1);
      key_jump = 1'b0;
      tick(12);
      n_checks++;
      if (state !== FALL || ypos !== 12'd664) begin
         n_fail++;
         $display("FAIL rejump_after_reset: got st=%0d y=%0d, expected 3 664", state, ypos);
      end
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_walk();
      test_climb();
      test_jump();
      test_fall();
      test_ramp();
      test_edges();
      test_reset_mid_jump();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
